// File: rtl/cpu_hazard.sv
// cpu_hazard -- operand bypass selection and hazard control for a short
// in-order pipeline.
//
// Tracks the destination register (and whether it is a load) of the
// instructions in stages 3 and 4, and from that selects operand bypasses for
// the stage-2 instruction. It detects load-use hazards, which hold stages 1-2
// for one cycle and inject a bubble into stage 3. It also freezes the whole
// pipeline while data memory is busy, and counts frozen/held cycles.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   p2_valid                     stage-2 slot holds a real instruction
//   p2_reg_a/b, p2_uses_a/b      stage-2 source registers and their use flags
//   p2_reg_d, p2_is_load         stage-2 destination (0 = none) and load flag
//   p3_flush                     taken branch in stage 3 kills stage 2
//   mem_busy                     data memory not ready
//   p2_bypass_a3/b3, a4/b4       operand bypass selects (stage 3 / stage 4)
//   stall                        global freeze (equals mem_busy)
//   p2_hold                      load-use hold of stages 1-2 plus a bubble
//   p3_reg_d, p4_reg_d           tracked destinations (0 = no write)
//   stall_count                  cycles with stall or p2_hold, wraps at 2^32
module cpu_hazard (
  input  logic        clock,
  input  logic        reset,
  input  logic        p2_valid,
  input  logic [4:0]  p2_reg_a,
  input  logic [4:0]  p2_reg_b,
  input  logic        p2_uses_a,
  input  logic        p2_uses_b,
  input  logic [4:0]  p2_reg_d,
  input  logic        p2_is_load,
  input  logic        p3_flush,
  input  logic        mem_busy,
  output logic        p2_bypass_a3,
  output logic        p2_bypass_b3,
  output logic        p2_bypass_a4,
  output logic        p2_bypass_b4,
  output logic        stall,
  output logic        p2_hold,
  output logic [4:0]  p3_reg_d,
  output logic [4:0]  p4_reg_d,
  output logic [31:0] stall_count
);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t state;
  logic   p3_is_load;
  logic   hit_a3, hit_b3, hit_a4, hit_b4;

  always_comb begin
    // Register 0 never matches, so it can never bypass or cause a hazard.
    hit_a3 = p2_uses_a && (p2_reg_a != 5'd0) && (p2_reg_a == p3_reg_d);
    hit_b3 = p2_uses_b && (p2_reg_b != 5'd0) && (p2_reg_b == p3_reg_d);
    hit_a4 = p2_uses_a && (p2_reg_a != 5'd0) && (p2_reg_a == p4_reg_d);
    hit_b4 = p2_uses_b && (p2_reg_b != 5'd0) && (p2_reg_b == p4_reg_d);

    // A load in stage 3 has no result yet, so it cannot be forwarded.
    p2_bypass_a3 = hit_a3 && !p3_is_load;
    p2_bypass_b3 = hit_b3 && !p3_is_load;
    // The younger producer in stage 3 wins over stage 4.
    p2_bypass_a4 = hit_a4 && !p2_bypass_a3;
    p2_bypass_b4 = hit_b4 && !p2_bypass_b3;

    stall   = mem_busy;
    p2_hold = p2_valid && p3_is_load && (hit_a3 || hit_b3) && !p3_flush;
  end

  // Tracked registers advance on any edge where mem_busy is low, including
  // the edge that leaves MEMWAIT, so a hazard pending across a memory stall
  // is re-evaluated and resolved on the first released cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      p3_reg_d    <= '0;
      p3_is_load  <= 1'b0;
      p4_reg_d    <= '0;
      stall_count <= '0;
    end else begin
      case (state)
        RUN:     if (mem_busy)  state <= MEMWAIT;
        MEMWAIT: if (!mem_busy) state <= RUN;
        default: state <= RUN;
      endcase

      if (!stall) begin
        p4_reg_d <= p3_reg_d;
        if (p3_flush || p2_hold || !p2_valid) begin
          p3_reg_d   <= '0;
          p3_is_load <= 1'b0;
        end else begin
          p3_reg_d   <= p2_reg_d;
          p3_is_load <= p2_is_load;
        end
      end

      if (stall || p2_hold)
        stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_hazard.sv
module tb_cpu_hazard;

  logic        clock = 1'b0;
  logic        reset;
  logic        p2_valid;
  logic [4:0]  p2_reg_a, p2_reg_b, p2_reg_d;
  logic        p2_uses_a, p2_uses_b, p2_is_load, p3_flush, mem_busy;
  logic        p2_bypass_a3, p2_bypass_b3, p2_bypass_a4, p2_bypass_b4;
  logic        stall, p2_hold;
  logic [4:0]  p3_reg_d, p4_reg_d;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cpu_hazard dut (
    .clock(clock), .reset(reset),
    .p2_valid(p2_valid), .p2_reg_a(p2_reg_a), .p2_reg_b(p2_reg_b),
    .p2_uses_a(p2_uses_a), .p2_uses_b(p2_uses_b), .p2_reg_d(p2_reg_d),
    .p2_is_load(p2_is_load), .p3_flush(p3_flush), .mem_busy(mem_busy),
    .p2_bypass_a3(p2_bypass_a3), .p2_bypass_b3(p2_bypass_b3),
    .p2_bypass_a4(p2_bypass_a4), .p2_bypass_b4(p2_bypass_b4),
    .stall(stall), .p2_hold(p2_hold),
    .p3_reg_d(p3_reg_d), .p4_reg_d(p4_reg_d), .stall_count(stall_count)
  );

  // Reference model: the instruction occupying each later stage.
  typedef struct {
    logic [4:0] dest;
    logic       load;
  } slot_t;

  slot_t       st3, st4;
  logic [31:0] m_cnt;

  wire logic [15:0] obs = {p2_bypass_a3, p2_bypass_b3, p2_bypass_a4, p2_bypass_b4,
                           stall, p2_hold, p3_reg_d, p4_reg_d};

  function automatic logic src_hit(input logic uses, input logic [4:0] r,
                                   input logic [4:0] dest);
    return uses && r != 0 && r == dest;
  endfunction

  function automatic logic exp_hold();
    return p2_valid && st3.load && !p3_flush &&
           (src_hit(p2_uses_a, p2_reg_a, st3.dest) || src_hit(p2_uses_b, p2_reg_b, st3.dest));
  endfunction

  function automatic logic [15:0] exp_vec();
    logic ba3, bb3, ba4, bb4;
    ba3 = src_hit(p2_uses_a, p2_reg_a, st3.dest) && !st3.load;
    bb3 = src_hit(p2_uses_b, p2_reg_b, st3.dest) && !st3.load;
    ba4 = src_hit(p2_uses_a, p2_reg_a, st4.dest) && !ba3;
    bb4 = src_hit(p2_uses_b, p2_reg_b, st4.dest) && !bb3;
    return {ba3, bb3, ba4, bb4, mem_busy, exp_hold(), st3.dest, st4.dest};
  endfunction

  task automatic model_clear();
    st3 = '{5'd0, 1'b0};
    st4 = '{5'd0, 1'b0};
    m_cnt = 32'd0;
  endtask

  // Advance one clock edge, moving the model pipeline the same way.
  task automatic tick();
    logic h;
    h = exp_hold();
    @(posedge clock);
    if (reset) model_clear();
    else begin
      if (!mem_busy) begin
        st4 = st3;
        if (p3_flush || h || !p2_valid) st3 = '{5'd0, 1'b0};
        else st3 = '{p2_reg_d, p2_is_load};
      end
      if (mem_busy || h) m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                       input logic ua, input logic ub, input logic [4:0] rd,
                       input logic ld, input logic fl, input logic mb);
    p2_valid = v; p2_reg_a = ra; p2_reg_b = rb; p2_uses_a = ua; p2_uses_b = ub;
    p2_reg_d = rd; p2_is_load = ld; p3_flush = fl; mem_busy = mb;
    #3;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 5, 5, 1, 1, 5, 1, 0, 0);
    model_clear();
    checks++;
    if (obs !== 16'h0000) begin errors++; $display("FAIL reset_outputs got=%h exp=0000", obs); end
    checks++;
    if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", stall_count); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_alu_back_to_back();
    do_reset();
    drive(1, 1, 2, 1, 1, 5, 0, 0, 0);
    tick();
    drive(1, 5, 6, 1, 1, 10, 0, 0, 0);
    checks++;
    if (p2_bypass_a3 !== 1'b1 || p2_hold !== 1'b0) begin
      errors++; $display("FAIL b2b_bypass got a3=%b hold=%b exp a3=1 hold=0", p2_bypass_a3, p2_hold);
    end
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL b2b_model got=%h exp=%h", obs, exp_vec()); end
    tick();
  endtask

  task automatic test_distance_two();
    do_reset();
    drive(1, 1, 2, 1, 1, 7, 0, 0, 0); tick();
    drive(1, 3, 4, 1, 1, 8, 0, 0, 0); tick();
    drive(1, 1, 7, 1, 1, 9, 0, 0, 0);
    checks++;
    if (p2_bypass_b4 !== 1'b1 || p2_bypass_b3 !== 1'b0) begin
      errors++; $display("FAIL dist2_bypass got b4=%b b3=%b exp b4=1 b3=0", p2_bypass_b4, p2_bypass_b3);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    drive(1, 3, 1, 1, 0, 8, 0, 0, 0);
    checks++;
    if (p2_hold !== 1'b1) begin errors++; $display("FAIL lu_hold got=%b exp=1", p2_hold); end
    tick();
    checks++;
    if (p3_reg_d !== 5'd0 || p2_hold !== 1'b0 || p2_bypass_a4 !== 1'b1) begin
      errors++; $display("FAIL lu_bubble got p3=%0d hold=%b a4=%b exp p3=0 hold=0 a4=1",
                         p3_reg_d, p2_hold, p2_bypass_a4);
    end
    tick();
    checks++;
    if (stall_count !== 32'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
  endtask

  task automatic test_reg0_priority();
    do_reset();
    drive(1, 0, 0, 1, 1, 4, 0, 0, 0);
    checks++;
    if (obs[15:12] !== 4'b0000) begin errors++; $display("FAIL r0_bypass got=%b exp=0000", obs[15:12]); end
    drive(1, 1, 1, 1, 1, 9, 0, 0, 0); tick();
    drive(1, 1, 1, 1, 1, 9, 0, 0, 0); tick();
    drive(1, 9, 0, 1, 0, 2, 0, 0, 0);
    checks++;
    if (p2_bypass_a3 !== 1'b1 || p2_bypass_a4 !== 1'b0) begin
      errors++; $display("FAIL prio_bypass got a3=%b a4=%b exp a3=1 a4=0", p2_bypass_a3, p2_bypass_a4);
    end
    tick();
  endtask

  task automatic test_memwait();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    drive(1, 0, 3, 0, 1, 8, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL mw_stall cyc=%0d got=%b exp=1", i, stall); end
      tick();
      checks++;
      if (p3_reg_d !== 5'd3 || p4_reg_d !== 5'd0) begin
        errors++; $display("FAIL mw_frozen cyc=%0d got p3=%0d p4=%0d exp p3=3 p4=0", i, p3_reg_d, p4_reg_d);
      end
    end
    checks++;
    if (stall_count !== 32'd3) begin errors++; $display("FAIL mw_count3 got=%0d exp=3", stall_count); end
    drive(1, 0, 3, 0, 1, 8, 0, 0, 0);
    checks++;
    if (p2_hold !== 1'b1) begin errors++; $display("FAIL mw_hold_after got=%b exp=1", p2_hold); end
    tick();
    checks++;
    if (stall_count !== 32'd4 || p3_reg_d !== 5'd0 || p4_reg_d !== 5'd3) begin
      errors++; $display("FAIL mw_release got cnt=%0d p3=%0d p4=%0d exp cnt=4 p3=0 p4=3",
                         stall_count, p3_reg_d, p4_reg_d);
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    drive(1, 3, 0, 1, 0, 8, 0, 1, 0);
    checks++;
    if (p2_hold !== 1'b0) begin errors++; $display("FAIL flush_hold got=%b exp=0", p2_hold); end
    tick();
    checks++;
    if (p3_reg_d !== 5'd0) begin errors++; $display("FAIL flush_p3 got=%0d exp=0", p3_reg_d); end
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0); tick();
    drive(1, 6, 0, 1, 0, 2, 0, 0, 1); tick();
    reset = 1'b1;
    drive(1, 6, 0, 1, 0, 2, 0, 0, 0);
    model_clear();
    checks++;
    if (obs !== 16'h0000 || stall_count !== 32'd0) begin
      errors++; $display("FAIL midreset got=%h cnt=%0d exp=0000 cnt=0", obs, stall_count);
    end
    tick();
    reset = 1'b0;
    drive(1, 6, 0, 1, 0, 2, 0, 0, 0); tick();
    checks++;
    if (stall_count !== 32'd0 || p3_reg_d !== 5'd2) begin
      errors++; $display("FAIL post_reset got cnt=%0d p3=%0d exp cnt=0 p3=2", stall_count, p3_reg_d);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
      if (reset) model_clear();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL rand_outputs n=%0d got=%h exp=%h", n, obs, exp_vec());
      end
      checks++;
      if (stall_count !== m_cnt) begin
        errors++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, stall_count, m_cnt);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    model_clear();
    test_reset();
    test_alu_back_to_back();
    test_distance_two();
    test_load_use();
    test_reg0_priority();
    test_memwait();
    test_flush_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
